ram_port_arbiter: RTL and testbench

Synchronous arbiter and sequencer that shares one `RAM` instance between two requesters: port A (ICU core data side) and port B (host/loader). It converts clocked valid/ready transactions into the RAM's asynchronous control protocol: read-address drive with a transparent output latch, and a write strobe whose rising edge commits the data. Transactions are strictly serialised, so RAM access never overlaps. The block sits between the core/loader and the `RAM` module.

---
 rtl/ram_port_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ram_port_arbiter
//  Description : Two-port (A = core data side, B = host/loader) arbiter and
//                sequencer in front of a single RAM with an asynchronous
//                control protocol: registered read address feeding a
//                transparent output latch, and a write strobe whose rising
//                edge commits the data. Transactions are fully serialised.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                  clk,
    input  logic                  reset,

    // Port A (core data side)
    input  logic                  a_valid,
    input  logic                  a_write,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ready,
    output logic                  a_resp,
    output logic [DATA_WIDTH-1:0] a_rdata,

    // Port B (host / loader)
    input  logic                  b_valid,
    input  logic                  b_write,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ready,
    output logic                  b_resp,
    output logic [DATA_WIDTH-1:0] b_rdata,

    // RAM side
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_write_address,
    output logic [ADDR_WIDTH-1:0] ram_read_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,

    // Status
    output logic                  busy,
    output logic                  last_grant
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_READ      = 3'd1;
    localparam logic [2:0] S_WR_SETUP  = 3'd2;
    localparam logic [2:0] S_WR_STROBE = 3'd3;
    localparam logic [2:0] S_WR_HOLD   = 3'd4;

    localparam bit c_RR_EN = (ROUND_ROBIN != 0);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [2:0]            r_state;
    logic [2:0]            w_next_state;

    logic                  w_pick_a;
    logic                  w_pick_b;
    logic                  w_accept;
    logic                  w_sel_write;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_done;

    logic                  w_busy;
    logic                  w_a_ready;
    logic                  w_b_ready;

    logic                  r_last_grant;
    logic                  r_a_resp;
    logic                  r_b_resp;
    logic [DATA_WIDTH-1:0] r_a_rdata;
    logic [DATA_WIDTH-1:0] r_b_rdata;
    logic                  r_ram_write;
    logic [ADDR_WIDTH-1:0] r_ram_write_address;
    logic [ADDR_WIDTH-1:0] r_ram_read_address;
    logic [DATA_WIDTH-1:0] r_ram_data_in;

    // ------------------------------------------------------------------------
    // Arbitration: single requester wins outright; on contention round-robin
    // hands the grant to the port that did not win last, fixed priority to A.
    // ------------------------------------------------------------------------
    always_comb begin
        w_pick_b    = b_valid && (!a_valid || (c_RR_EN && !r_last_grant));
        w_pick_a    = a_valid && !w_pick_b;
        w_accept    = (r_state == S_IDLE) && (w_pick_a || w_pick_b);
        w_sel_write = w_pick_b ? b_write : a_write;
        w_sel_addr  = w_pick_b ? b_addr  : a_addr;
        w_sel_wdata = w_pick_b ? b_wdata : a_wdata;
        // A transaction completes on leaving READ or WR_HOLD
        w_done      = (r_state == S_READ) || (r_state == S_WR_HOLD);
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic: reads take one busy cycle, writes take three
    // (setup / strobe / hold) so address and data bracket the strobe edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_sel_write ? S_WR_SETUP : S_READ;
                end
            end
            S_READ:      w_next_state = S_IDLE;
            S_WR_SETUP:  w_next_state = S_WR_STROBE;
            S_WR_STROBE: w_next_state = S_WR_HOLD;
            S_WR_HOLD:   w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM output logic: ready is a same-cycle accept pulse in IDLE only
    // ------------------------------------------------------------------------
    always_comb begin
        w_busy    = (r_state != S_IDLE);
        w_a_ready = (r_state == S_IDLE) && w_pick_a;
        w_b_ready = (r_state == S_IDLE) && w_pick_b;
    end

    // ------------------------------------------------------------------------
    // Grant history: updated on every accept, reset so A wins first contention
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_pick_b;
        end
    end

    // ------------------------------------------------------------------------
    // RAM address/data capture: loaded on the accept edge so they are already
    // stable throughout READ, or throughout WR_SETUP..WR_HOLD for writes, and
    // held at all other times.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ram_write_address <= '0;
            r_ram_data_in       <= '0;
            r_ram_read_address  <= '0;
        end else if (w_accept) begin
            if (w_sel_write) begin
                r_ram_write_address <= w_sel_addr;
                r_ram_data_in       <= w_sel_wdata;
            end else begin
                r_ram_read_address  <= w_sel_addr;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Write strobe: registered from the next state so it is glitch-free and
    // high exactly for the WR_STROBE cycle; reset drops it on the reset edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ram_write <= 1'b0;
        end else begin
            r_ram_write <= (w_next_state == S_WR_STROBE);
        end
    end

    // ------------------------------------------------------------------------
    // Completion pulses: one cycle in the IDLE cycle following READ/WR_HOLD
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_resp <= 1'b0;
            r_b_resp <= 1'b0;
        end else begin
            r_a_resp <= w_done && !r_last_grant;
            r_b_resp <= w_done &&  r_last_grant;
        end
    end

    // ------------------------------------------------------------------------
    // Read data return: sample the RAM latch at the end of READ into the
    // grantee's holding register; writes leave both registers untouched.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else if (r_state == S_READ) begin
            if (r_last_grant) begin
                r_b_rdata <= ram_data_out;
            end else begin
                r_a_rdata <= ram_data_out;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign a_ready           = w_a_ready;
    assign b_ready           = w_b_ready;
    assign a_resp            = r_a_resp;
    assign b_resp            = r_b_resp;
    assign a_rdata           = r_a_rdata;
    assign b_rdata           = r_b_rdata;
    assign ram_write         = r_ram_write;
    assign ram_write_address = r_ram_write_address;
    assign ram_read_address  = r_ram_read_address;
    assign ram_data_in       = r_ram_data_in;
    assign busy              = w_busy;
    assign last_grant        = r_last_grant;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ram_port_arbiter
//  Description : Self-checking bench for ram_port_arbiter. Instance 0 runs
//                round-robin, instance 1 fixed priority; each drives its own
//                behavioural strobe-edge RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       reset [2];
    logic       a_valid [2], a_write [2], a_ready [2], a_resp [2];
    logic [7:0] a_addr [2], a_wdata [2], a_rdata [2];
    logic       b_valid [2], b_write [2], b_ready [2], b_resp [2];
    logic [7:0] b_addr [2], b_wdata [2], b_rdata [2];
    logic       ram_write [2];
    logic [7:0] ram_write_address [2], ram_read_address [2];
    logic [7:0] ram_data_in [2], ram_data_out [2];
    logic       busy [2], last_grant [2];

    logic [7:0] mem [2][256];     // RAM contents seen by each DUT
    logic [7:0] m_mem [2][256];   // reference memory model
    logic       m_last [2];       // reference last grant (0=A,1=B)
    logic [7:0] m_rdata [2][2];   // reference held rdata [dut][port]

    int checks   = 0;
    int failures = 0;
    int grant_q [$];
    int resp_seen [2];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            ram_port_arbiter #(
                .DATA_WIDTH (8),
                .ADDR_WIDTH (8),
                .ROUND_ROBIN((g == 0) ? 1 : 0)
            ) u_dut (
                .clk              (clk),
                .reset            (reset[g]),
                .a_valid          (a_valid[g]),
                .a_write          (a_write[g]),
                .a_addr           (a_addr[g]),
                .a_wdata          (a_wdata[g]),
                .a_ready          (a_ready[g]),
                .a_resp           (a_resp[g]),
                .a_rdata          (a_rdata[g]),
                .b_valid          (b_valid[g]),
                .b_write          (b_write[g]),
                .b_addr           (b_addr[g]),
                .b_wdata          (b_wdata[g]),
                .b_ready          (b_ready[g]),
                .b_resp           (b_resp[g]),
                .b_rdata          (b_rdata[g]),
                .ram_write        (ram_write[g]),
                .ram_write_address(ram_write_address[g]),
                .ram_read_address (ram_read_address[g]),
                .ram_data_in      (ram_data_in[g]),
                .ram_data_out     (ram_data_out[g]),
                .busy             (busy[g]),
                .last_grant       (last_grant[g])
            );
            // Transparent read latch of the RAM
            assign ram_data_out[g] = mem[g][ram_write_address[g] == ram_write_address[g] ? ram_read_address[g] : 8'h00];
        end
    endgenerate

    // RAM write commit on the rising edge of each strobe
    initial begin
        logic prev [2];
        for (int d = 0; d < 2; d++) begin
            prev[d] = 1'b0;
            for (int i = 0; i < 256; i++) mem[d][i] = 8'h00;
        end
        forever begin
            @(ram_write[0] or ram_write[1]);
            for (int d = 0; d < 2; d++) begin
                if (ram_write[d] === 1'b1 && !prev[d]) mem[d][ram_write_address[d]] = ram_data_in[d];
                prev[d] = (ram_write[d] === 1'b1);
            end
        end
    end

    task automatic idle_inputs(input int d);
        a_valid[d] = 1'b0; a_write[d] = 1'b0; a_addr[d] = 8'h00; a_wdata[d] = 8'h00;
        b_valid[d] = 1'b0; b_write[d] = 1'b0; b_addr[d] = 8'h00; b_wdata[d] = 8'h00;
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        idle_inputs(d);
        reset[d] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset[d] = 1'b0;
        m_last[d] = 1'b1;
        m_rdata[d][0] = 8'h00;
        m_rdata[d][1] = 8'h00;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            idle_inputs(d);
            reset[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            logic [6:0] got;
            got = {a_ready[d], b_ready[d], a_resp[d], b_resp[d], busy[d], ram_write[d], last_grant[d]};
            checks++;
            if (got !== 7'b0000001) begin
                failures++;
                $display("FAIL reset_ctrl dut%0d: got %b expected 0000001", d, got);
            end
            checks++;
            if ({ram_write_address[d], ram_read_address[d], ram_data_in[d], a_rdata[d], b_rdata[d]} !== 40'h0) begin
                failures++;
                $display("FAIL reset_regs dut%0d: got %h expected 0", d,
                         {ram_write_address[d], ram_read_address[d], ram_data_in[d], a_rdata[d], b_rdata[d]});
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b0;
            m_last[d] = 1'b1;
            m_rdata[d][0] = 8'h00;
            m_rdata[d][1] = 8'h00;
        end
    endtask

    // ------------------------------------------------------------------------
    // A writes 0x5A to 0x10, then reads it back in the write's resp cycle
    task automatic test_write_read();
        @(negedge clk);
        a_valid[0] = 1'b1; a_write[0] = 1'b1; a_addr[0] = 8'h10; a_wdata[0] = 8'h5A;
        #1;
        checks++;
        if (a_ready[0] !== 1'b1) begin failures++; $display("FAIL wr_ready: got %b expected 1", a_ready[0]); end
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            a_valid[0] = 1'b0;
            #1;
            checks++;
            if (ram_write[0] !== (t == 2)) begin
                failures++; $display("FAIL wr_strobe T+%0d: got %b expected %b", t, ram_write[0], (t == 2));
            end
            checks++;
            if ({ram_write_address[0], ram_data_in[0], busy[0], a_resp[0]} !== {8'h10, 8'h5A, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL wr_setup_hold T+%0d: got addr %h data %h busy %b resp %b expected 10 5a 1 0",
                         t, ram_write_address[0], ram_data_in[0], busy[0], a_resp[0]);
            end
        end
        @(negedge clk);
        a_valid[0] = 1'b1; a_write[0] = 1'b0; a_addr[0] = 8'h10;
        #1;
        checks++;
        if ({a_resp[0], a_ready[0], b_resp[0], busy[0]} !== 4'b1100) begin
            failures++; $display("FAIL wr_resp T+4: got resp/ready/b_resp/busy %b expected 1100",
                                 {a_resp[0], a_ready[0], b_resp[0], busy[0]});
        end
        @(negedge clk);
        a_valid[0] = 1'b0;
        #1;
        checks++;
        if ({busy[0], ram_write[0], a_resp[0], ram_read_address[0]} !== {3'b100, 8'h10}) begin
            failures++; $display("FAIL rd_busy: got busy/wr/resp %b addr %h expected 100 10",
                                 {busy[0], ram_write[0], a_resp[0]}, ram_read_address[0]);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({a_resp[0], b_resp[0], busy[0], a_rdata[0]} !== {3'b100, 8'h5A}) begin
            failures++; $display("FAIL rd_after_wr: got resp/b_resp/busy %b rdata %h expected 100 5a",
                                 {a_resp[0], b_resp[0], busy[0]}, a_rdata[0]);
        end
        m_mem[0][8'h10] = 8'h5A;
        m_last[0] = 1'b0;
        m_rdata[0][0] = 8'h5A;
    endtask

    // ------------------------------------------------------------------------
    // B preloads 0x20=0xC3, then reads it while A raises valid during READ
    task automatic test_read_during_busy();
        @(negedge clk);
        b_valid[0] = 1'b1; b_write[0] = 1'b1; b_addr[0] = 8'h20; b_wdata[0] = 8'hC3;
        #1;
        checks++;
        if (b_ready[0] !== 1'b1) begin failures++; $display("FAIL preload_ready: got %b expected 1", b_ready[0]); end
        @(negedge clk);
        b_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        b_valid[0] = 1'b1; b_write[0] = 1'b0; b_addr[0] = 8'h20;
        #1;
        checks++;
        if ({b_resp[0], b_ready[0]} !== 2'b11) begin
            failures++; $display("FAIL preload_resp_ready: got %b expected 11", {b_resp[0], b_ready[0]});
        end
        @(negedge clk);
        b_valid[0] = 1'b0;
        a_valid[0] = 1'b1; a_write[0] = 1'b0; a_addr[0] = 8'h10;
        #1;
        checks++;
        if ({a_ready[0], busy[0]} !== 2'b01) begin
            failures++; $display("FAIL busy_wait: got ready/busy %b expected 01", {a_ready[0], busy[0]});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({b_resp[0], a_ready[0], b_rdata[0]} !== {2'b11, 8'hC3}) begin
            failures++; $display("FAIL b_read_c3: got resp/a_ready %b rdata %h expected 11 c3",
                                 {b_resp[0], a_ready[0]}, b_rdata[0]);
        end
        @(negedge clk);
        a_valid[0] = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({a_resp[0], a_rdata[0]} !== {1'b1, m_mem[0][8'h10]}) begin
            failures++; $display("FAIL a_read_after_wait: got resp %b rdata %h expected 1 %h",
                                 a_resp[0], a_rdata[0], m_mem[0][8'h10]);
        end
        m_mem[0][8'h20] = 8'hC3;
        m_rdata[0][1] = 8'hC3;
        m_rdata[0][0] = m_mem[0][8'h10];
        m_last[0] = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // B write interrupted by reset in WR_SETUP (hold_phase=0) or WR_HOLD (1)
    task automatic test_reset_mid_write(input int hold_phase);
        logic [7:0] data;
        logic [7:0] exp;
        data = ~m_mem[0][8'h30];
        @(negedge clk);
        b_valid[0] = 1'b1; b_write[0] = 1'b1; b_addr[0] = 8'h30; b_wdata[0] = data;
        #1;
        checks++;
        if (b_ready[0] !== 1'b1) begin failures++; $display("FAIL rstmid_ready%0d: got %b expected 1", hold_phase, b_ready[0]); end
        @(negedge clk);
        b_valid[0] = 1'b0;
        if (hold_phase != 0) begin
            @(negedge clk);
            #1;
            checks++;
            if (ram_write[0] !== 1'b1) begin failures++; $display("FAIL rstmid_strobe: got %b expected 1", ram_write[0]); end
            @(negedge clk);
        end
        reset[0] = 1'b1;
        @(negedge clk);
        reset[0] = 1'b0;
        m_last[0] = 1'b1;
        m_rdata[0][0] = 8'h00;
        m_rdata[0][1] = 8'h00;
        for (int t = 0; t < 5; t++) begin
            #1;
            checks++;
            if ({b_resp[0], a_resp[0], ram_write[0], busy[0]} !== 4'b0000) begin
                failures++; $display("FAIL rstmid_quiet%0d t%0d: got resp/resp/wr/busy %b expected 0000",
                                     hold_phase, t, {b_resp[0], a_resp[0], ram_write[0], busy[0]});
            end
            @(negedge clk);
        end
        if (hold_phase != 0) m_mem[0][8'h30] = data;
        exp = m_mem[0][8'h30];
        checks++;
        if (mem[0][8'h30] !== exp) begin
            failures++; $display("FAIL rstmid_mem%0d: got %h expected %h", hold_phase, mem[0][8'h30], exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Randomised traffic against a transaction-level timing model:
    // an accepted read frees the RAM 2 cycles later with resp then, a write
    // strobes 2 cycles after accept and frees/responds 4 cycles after accept.
    task automatic run_traffic(input int d, input int n_each, input int pct_valid,
                               input int pct_drop, input int max_cyc);
        int         left [2];
        logic       pend [2];
        logic       pw [2];
        logic [7:0] pa [2];
        logic [7:0] pd [2];
        int  free_cyc, resp_cyc, resp_port, strobe_cyc, win;
        logic resp_is_read;
        logic [7:0] resp_data;
        bit  done;
        free_cyc = 0; resp_cyc = -1; resp_port = 0; strobe_cyc = -1;
        resp_is_read = 1'b0; resp_data = 8'h00; done = 1'b0;
        grant_q.delete();
        for (int p = 0; p < 2; p++) begin
            left[p] = n_each; pend[p] = 1'b0; pw[p] = 1'b0; pa[p] = 8'h00; pd[p] = 8'h00;
            resp_seen[p] = 0;
        end
        for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && left[p] > 0 && $urandom_range(99) < pct_valid) begin
                    pend[p] = 1'b1;
                    pw[p]   = 1'($urandom_range(1));
                    pa[p]   = 8'h40 + 8'($urandom_range(15));
                    pd[p]   = 8'($urandom_range(255));
                end else if (pend[p] && cyc < free_cyc && $urandom_range(99) < pct_drop) begin
                    pend[p] = 1'b0;
                end
            end
            a_valid[d] = pend[0]; a_write[d] = pw[0]; a_addr[d] = pa[0]; a_wdata[d] = pd[0];
            b_valid[d] = pend[1]; b_write[d] = pw[1]; b_addr[d] = pa[1]; b_wdata[d] = pd[1];
            #1;
            win = -1;
            if (cyc >= free_cyc) begin
                if (pend[0] && pend[1]) win = (d == 0 && m_last[d] == 1'b0) ? 1 : 0;
                else if (pend[0])       win = 0;
                else if (pend[1])       win = 1;
            end
            if (cyc == resp_cyc && resp_is_read) m_rdata[d][resp_port] = resp_data;
            checks++;
            if ({busy[d], ram_write[d], last_grant[d]} !== {(cyc < free_cyc), (cyc == strobe_cyc), m_last[d]}) begin
                failures++;
                $display("FAIL traffic_status dut%0d cyc%0d: got busy/wr/last %b expected %b", d, cyc,
                         {busy[d], ram_write[d], last_grant[d]}, {(cyc < free_cyc), (cyc == strobe_cyc), m_last[d]});
            end
            for (int p = 0; p < 2; p++) begin
                logic rdy, rsp;
                logic [7:0] rd;
                rdy = (p == 1) ? b_ready[d] : a_ready[d];
                rsp = (p == 1) ? b_resp[d]  : a_resp[d];
                rd  = (p == 1) ? b_rdata[d] : a_rdata[d];
                if (rsp === 1'b1) resp_seen[p]++;
                checks++;
                if ({rdy, rsp} !== {(win == p), (cyc == resp_cyc && resp_port == p)}) begin
                    failures++;
                    $display("FAIL traffic_handshake dut%0d port%0d cyc%0d: got ready/resp %b expected %b", d, p, cyc,
                             {rdy, rsp}, {(win == p), (cyc == resp_cyc && resp_port == p)});
                end
                checks++;
                if (rd !== m_rdata[d][p]) begin
                    failures++;
                    $display("FAIL traffic_rdata dut%0d port%0d cyc%0d: got %h expected %h", d, p, cyc, rd, m_rdata[d][p]);
                end
            end
            if (win >= 0) begin
                m_last[d] = (win == 1);
                grant_q.push_back(win);
                if (pw[win]) begin
                    m_mem[d][pa[win]] = pd[win];
                    free_cyc   = cyc + 4;
                    strobe_cyc = cyc + 2;
                end else begin
                    resp_data = m_mem[d][pa[win]];
                    free_cyc  = cyc + 2;
                end
                resp_is_read = !pw[win];
                resp_cyc  = free_cyc;
                resp_port = win;
                pend[win] = 1'b0;
                left[win]--;
            end
            if (left[0] == 0 && left[1] == 0 && cyc >= resp_cyc) done = 1'b1;
        end
        @(negedge clk);
        idle_inputs(d);
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL traffic_timeout dut%0d: got left %0d/%0d expected 0/0", d, left[0], left[1]);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_contention(input int d);
        do_reset(d);
        run_traffic(d, 4, 100, 0, 200);
        checks++;
        if (grant_q.size() != 8 || resp_seen[0] != 4 || resp_seen[1] != 4) begin
            failures++;
            $display("FAIL contention_count dut%0d: got grants %0d resp %0d/%0d expected 8 4/4",
                     d, grant_q.size(), resp_seen[0], resp_seen[1]);
        end else begin
            for (int i = 0; i < 8; i++) begin
                int exp;
                exp = (d == 0) ? (i % 2) : ((i < 4) ? 0 : 1);
                checks++;
                if (grant_q[i] != exp) begin
                    failures++;
                    $display("FAIL contention_order dut%0d grant%0d: got %0d expected %0d", d, i, grant_q[i], exp);
                end
            end
        end
    endtask

    task automatic test_random(input int d);
        run_traffic(d, 20, 40, 20, 1000);
        checks++;
        if (resp_seen[0] + resp_seen[1] != 40) begin
            failures++;
            $display("FAIL random_resp_count dut%0d: got %0d expected 40", d, resp_seen[0] + resp_seen[1]);
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) m_mem[d][i] = 8'h00;
            idle_inputs(d);
            reset[d] = 1'b1;
        end
        test_reset();
        test_write_read();
        test_read_during_busy();
        test_reset_mid_write(0);
        test_reset_mid_write(1);
        test_contention(0);
        test_contention(1);
        test_random(0);
        test_random(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
